// File: rtl/div_pkg.sv
// Shared constants, opcodes and state encoding for the iterative divider.
// Latency: n/a (declarations and pure helper functions only).
// Backpressure: n/a.
package div_pkg;

    localparam int XLEN = 32;

    // Opcode encoding: op[0] selects unsigned, op[1] selects remainder.
    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    localparam logic [XLEN-1:0] DIV0_QUOT = 32'hFFFF_FFFF;
    localparam logic [XLEN-1:0] INT_MIN   = 32'h8000_0000;

    // FSM state type, kept as plain constants so older code can still compare against them.
    typedef logic [1:0] state_t;
    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_CALC = 2'd1;
    localparam state_t S_FIX  = 2'd2;
    localparam state_t S_DONE = 2'd3;

    // Two's complement negation modulo 2^32.
    function automatic logic [XLEN-1:0] neg32(input logic [XLEN-1:0] x);
        return (~x) + 32'd1;
    endfunction

    // Magnitude of a signed value; INT_MIN maps onto itself, read as unsigned 2^31.
    function automatic logic [XLEN-1:0] abs32(input logic [XLEN-1:0] x);
        return x[XLEN-1] ? neg32(x) : x;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration on a 33-bit partial remainder.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the outputs.
module div_step
    import div_pkg::*;
(
    input  logic [XLEN:0]   rem_in,
    input  logic            dvd_bit,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN:0]   rem_out,
    output logic            q_bit
);

    logic [XLEN+1:0] shifted;
    logic [XLEN+1:0] diff;

    // Shift in the next dividend bit and keep the difference only if it stays non-negative.
    always_comb begin
        shifted = {rem_in, dvd_bit};
        diff    = shifted - {2'b00, divisor};
        q_bit   = ~diff[XLEN+1];
        rem_out = diff[XLEN+1] ? shifted[XLEN:0] : diff[XLEN:0];
    end

endmodule

// File: rtl/div_ctrl.sv
// 32-bit signed/unsigned divide/remainder controller with a valid/ready request and result handshake.
// Latency: 34 cycles to out_valid normally, 1 cycle for divide-by-zero and signed overflow.
// Backpressure: result holds in DONE until out_ready; in_ready only in IDLE. Optional flush via DIV_CTRL_FLUSH_EN.
module div_ctrl
    import div_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
`ifdef DIV_CTRL_FLUSH_EN
    ,
    input  logic            flush
`endif
);

    state_t          state;
    logic [4:0]      cnt;
    logic            is_rem_q;
    logic            neg_q_q;
    logic            neg_r_q;
    logic [XLEN-1:0] dvd_q;     // remaining dividend bits, quotient bits shift in at the bottom
    logic [XLEN-1:0] dvs_q;
    logic [XLEN:0]   rem_q;

    logic            accept;
    logic            is_signed;
    logic            dvd_neg;
    logic            dvs_neg;
    logic            div_zero;
    logic            overflow;
    logic            flush_req;
    logic [XLEN:0]   step_rem;
    logic            step_q;

    assign in_ready  = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign out_valid = (state == S_DONE);
    assign accept    = in_valid & in_ready;

`ifdef DIV_CTRL_FLUSH_EN
    assign flush_req = flush;
`else
    assign flush_req = 1'b0;
`endif

    // Decode the incoming request for sign handling and the single-cycle special cases.
    always_comb begin
        is_signed = ~op[0];
        dvd_neg   = is_signed & dividend[XLEN-1];
        dvs_neg   = is_signed & divisor[XLEN-1];
        div_zero  = (divisor == '0);
        overflow  = is_signed && (dividend == INT_MIN) && (divisor == DIV0_QUOT);
    end

    div_step u_step (
        .rem_in  (rem_q),
        .dvd_bit (dvd_q[XLEN-1]),
        .divisor (dvs_q),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    // Control FSM plus datapath registers; flush (when built in) overrides the next state last.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            is_rem_q <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            result   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        cnt      <= '0;
                        rem_q    <= '0;
                        is_rem_q <= op[1];
                        neg_q_q  <= dvd_neg ^ dvs_neg;
                        neg_r_q  <= dvd_neg;
                        dvd_q    <= is_signed ? abs32(dividend) : dividend;
                        dvs_q    <= is_signed ? abs32(divisor) : divisor;
                        if (div_zero) begin
                            result <= op[1] ? dividend : DIV0_QUOT;
                            state  <= S_DONE;
                        end else if (overflow) begin
                            result <= op[1] ? '0 : INT_MIN;
                            state  <= S_DONE;
                        end else begin
                            state  <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    rem_q <= step_rem;
                    dvd_q <= {dvd_q[XLEN-2:0], step_q};
                    cnt   <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (!flush_req) begin
                        if (is_rem_q) begin
                            result <= neg_r_q ? neg32(rem_q[XLEN-1:0]) : rem_q[XLEN-1:0];
                        end else begin
                            result <= neg_q_q ? neg32(dvd_q) : dvd_q;
                        end
                    end
                    state <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
            if (flush_req && (state != S_IDLE)) begin
                state <= S_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed self-checking bench for div_ctrl: signed/unsigned results, latency, special cases,
// backpressure, mid-operation reset and (when built in) flush.
// Outputs are sampled on the falling clock edge.
module tb_div_ctrl;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        busy;
`ifdef DIV_CTRL_FLUSH_EN
    logic        flush;
`endif

    int compared;
    int mismatched;

    div_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
`ifdef DIV_CTRL_FLUSH_EN
        ,
        .flush     (flush)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive a request at a falling edge and step past the acceptance edge; operands are then scrambled.
    task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                            input logic rdy);
        @(negedge clk);
        in_valid  = 1'b1;
        op        = o;
        dividend  = a;
        divisor   = b;
        out_ready = rdy;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = 32'h5A5A_1234;
        divisor  = 32'h0000_0003;
        op       = ~o;
    endtask

    // Issue a request and wait (bounded) for out_valid; lat counts falling edges since acceptance.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic rdy, output logic [31:0] res, output int lat);
        start_op(o, a, b, rdy);
        lat = 0;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
        end
        res = result;
    endtask

    task automatic test_reset;
        #1;
        compared++;
        if (out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        compared++;
        if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy got %b want 0", busy); end
        compared++;
        if (in_ready !== 1'b1) begin mismatched++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        compared++;
        if (result !== 32'h0) begin mismatched++; $display("FAIL reset_result got %h want 00000000", result); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        compared++;
        if (in_ready !== 1'b1) begin mismatched++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_div_signed;
        logic [31:0] res;
        int lat;
        run_op(2'b00, 32'hFFFF_FFF9, 32'd2, 1'b1, res, lat);
        compared++;
        if (res !== 32'hFFFF_FFFD) begin mismatched++; $display("FAIL div_m7_2 got %h want fffffffd", res); end
        compared++;
        if (lat !== 34) begin mismatched++; $display("FAIL div_latency got %0d want 34", lat); end
    endtask

    task automatic test_rem_unsigned;
        logic [31:0] res;
        int lat;
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b1, res, lat);
        compared++;
        if (res !== 32'hFFFF_FFFF) begin mismatched++; $display("FAIL rem_m7_2 got %h want ffffffff", res); end
        run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 1'b1, res, lat);
        compared++;
        if (res !== 32'h0000_0001) begin mismatched++; $display("FAIL remu_fff9_2 got %h want 00000001", res); end
        run_op(2'b01, 32'hFFFF_FFF9, 32'd2, 1'b1, res, lat);
        compared++;
        if (res !== 32'h7FFF_FFFC) begin mismatched++; $display("FAIL divu_fff9_2 got %h want 7ffffffc", res); end
        compared++;
        if (lat !== 34) begin mismatched++; $display("FAIL divu_latency got %0d want 34", lat); end
        run_op(2'b00, 32'd100, 32'hFFFF_FFF9, 1'b1, res, lat);
        compared++;
        if (res !== 32'hFFFF_FFF2) begin mismatched++; $display("FAIL div_100_m7 got %h want fffffff2", res); end
    endtask

    task automatic test_div_zero;
        logic [31:0] res;
        int lat;
        run_op(2'b01, 32'd100, 32'd0, 1'b1, res, lat);
        compared++;
        if (res !== 32'hFFFF_FFFF) begin mismatched++; $display("FAIL divu_by0 got %h want ffffffff", res); end
        compared++;
        if (lat !== 1) begin mismatched++; $display("FAIL divu_by0_latency got %0d want 1", lat); end
        run_op(2'b11, 32'd100, 32'd0, 1'b1, res, lat);
        compared++;
        if (res !== 32'd100) begin mismatched++; $display("FAIL remu_by0 got %h want 00000064", res); end
        compared++;
        if (lat !== 1) begin mismatched++; $display("FAIL remu_by0_latency got %0d want 1", lat); end
    endtask

    task automatic test_overflow;
        logic [31:0] res;
        int lat;
        run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, res, lat);
        compared++;
        if (res !== 32'h8000_0000) begin mismatched++; $display("FAIL div_ovf got %h want 80000000", res); end
        compared++;
        if (lat !== 1) begin mismatched++; $display("FAIL div_ovf_latency got %0d want 1", lat); end
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, res, lat);
        compared++;
        if (res !== 32'h0) begin mismatched++; $display("FAIL rem_ovf got %h want 00000000", res); end
        compared++;
        if (lat !== 1) begin mismatched++; $display("FAIL rem_ovf_latency got %0d want 1", lat); end
        run_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, res, lat);
        compared++;
        if (res !== 32'h0) begin mismatched++; $display("FAIL divu_intmin got %h want 00000000", res); end
    endtask

    task automatic test_backpressure;
        logic [31:0] res;
        int lat;
        run_op(2'b01, 32'd100, 32'd7, 1'b0, res, lat);
        compared++;
        if (res !== 32'd14) begin mismatched++; $display("FAIL bp_result got %h want 0000000e", res); end
        for (int i = 0; i < 5; i++) begin
            compared++;
            if (out_valid !== 1'b1 || result !== 32'd14) begin
                mismatched++;
                $display("FAIL bp_hold[%0d] got valid=%b result=%h want valid=1 result=0000000e", i, out_valid, result);
            end
            compared++;
            if (in_ready !== 1'b0 || busy !== 1'b1) begin
                mismatched++;
                $display("FAIL bp_flags[%0d] got in_ready=%b busy=%b want 0/1", i, in_ready, busy);
            end
            in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        compared++;
        if (out_valid !== 1'b1) begin mismatched++; $display("FAIL bp_before_release got %b want 1", out_valid); end
        out_ready = 1'b1;
        @(negedge clk);
        compared++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL bp_release got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
    endtask

    task automatic check_20_3(input string tag);
        logic [31:0] res;
        int lat;
        run_op(2'b00, 32'd20, 32'd3, 1'b1, res, lat);
        compared++;
        if (res !== 32'd6) begin mismatched++; $display("FAIL %s_div_20_3 got %h want 00000006", tag, res); end
    endtask

`ifdef DIV_CTRL_FLUSH_EN
    task automatic test_flush;
        logic seen;
        start_op(2'b00, 32'd1000, 32'd7, 1'b1);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        compared++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL flush_idle got busy=%b in_ready=%b out_valid=%b want 0/1/0", busy, in_ready, out_valid);
        end
        compared++;
        if (result !== 32'd14) begin mismatched++; $display("FAIL flush_result_kept got %h want 0000000e", result); end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        compared++;
        if (seen !== 1'b0) begin mismatched++; $display("FAIL flush_no_valid got pulse=1 want 0"); end
        check_20_3("flush");
    endtask
`endif

    task automatic test_reset_mid;
        logic seen;
        start_op(2'b00, 32'd1000, 32'd7, 1'b1);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        #1;
        compared++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL rst_mid got out_valid=%b busy=%b in_ready=%b want 0/0/1", out_valid, busy, in_ready);
        end
        compared++;
        if (result !== 32'h0) begin mismatched++; $display("FAIL rst_mid_result got %h want 00000000", result); end
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        compared++;
        if (seen !== 1'b0) begin mismatched++; $display("FAIL rst_mid_no_valid got pulse=1 want 0"); end
        compared++;
        if (in_ready !== 1'b1) begin mismatched++; $display("FAIL rst_mid_in_ready got %b want 1", in_ready); end
        check_20_3("rst");
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset      = 1'b1;
        in_valid   = 1'b0;
        op         = 2'b00;
        dividend   = '0;
        divisor    = '0;
        out_ready  = 1'b1;
`ifdef DIV_CTRL_FLUSH_EN
        flush      = 1'b0;
`endif
        test_reset();
        test_div_signed();
        test_rem_unsigned();
        test_div_zero();
        test_overflow();
        test_backpressure();
`ifdef DIV_CTRL_FLUSH_EN
        test_flush();
`endif
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 SHALL have ports (name  direction  width  meaning): clk  in  1  sole clock, rising edge.
REQ-002 reset  in  1  asynchronous, active-high.
REQ-003 in_valid  in  1  request valid; in_ready  out  1  controller can accept a request.
REQ-004 op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-005 dividend  in  32; divisor  in  32  operands, sampled on acceptance.
REQ-006 out_valid  out  1; out_ready  in  1  result handshake.
REQ-007 result  out  32  quotient or remainder selected by op.
REQ-008 busy  out  1  high in any state other than IDLE.
REQ-009 flush  in  1  abort the current operation; present only with DIV_CTRL_FLUSH_EN.

Function
REQ-010 Acceptance SHALL occur at a rising edge where in_valid and in_ready are both high; in_ready SHALL be high only in IDLE.
REQ-011 The FSM SHALL have states IDLE, CALC, FIX and DONE.
- IDLE->CALC on acceptance.
- CALC->FIX after 32 iterations.
- FIX->DONE always.
- DONE->IDLE when out_ready is high.
REQ-012 In CALC, one restoring shift-subtract step SHALL be performed per cycle on operand magnitudes.
- Operands are magnitudes for DIV/REM and raw values for DIVU/REMU.
- A 5-bit iteration counter runs 0..31.
REQ-013 In FIX:
- Quotient SHALL be negated when the operand signs differ (signed ops only).
- Remainder SHALL take the dividend sign (signed ops only).
- result SHALL be registered.
REQ-014 Normal latency: out_valid SHALL first be high 34 cycles after the acceptance edge.
REQ-015 Divisor zero SHALL bypass CALC/FIX and go to DONE with out_valid high 1 cycle after acceptance.
- DIV/DIVU result 0xFFFFFFFF.
- REM/REMU result dividend.
REQ-016 Signed overflow (DIV/REM, dividend 0x80000000, divisor 0xFFFFFFFF) SHALL take the same 1-cycle path.
- DIV result 0x80000000.
- REM result 0.
REQ-017 While out_valid is high and out_ready is low, result and out_valid SHALL hold stable; no new request SHALL be accepted.
REQ-018 out_valid SHALL be high only in DONE; result SHALL hold its last value outside DONE.
REQ-019 Arithmetic SHALL use a 33-bit partial remainder.
- Negation is two's complement modulo 2^32.
- |0x80000000| SHALL be handled as unsigned 0x80000000.
REQ-020 Inputs SHALL be ignored outside the acceptance edge; operand changes during CALC SHALL not affect the result.

Reset
REQ-021 On reset assertion, without waiting for a clock edge, the following SHALL take effect: state IDLE, out_valid 0, busy 0, result 0, counter 0, internal operand/remainder registers 0.
REQ-022 Reset mid-operation SHALL discard the operation with no out_valid pulse; in_ready SHALL be high while reset is held and after its release.

Configuration
REQ-023 Macro DIV_CTRL_FLUSH_EN defined: the flush port SHALL exist.
- flush high at an edge in CALC, FIX or DONE returns to IDLE at that edge.
- No out_valid pulse follows the flush.
- result is retained.
- flush in IDLE is ignored.
- flush and acceptance in the same cycle: acceptance wins.
REQ-024 Macro undefined: no flush port and no flush logic; behaviour otherwise identical.

Structure
REQ-025 Package div_pkg SHALL hold the following:
- XLEN=32.
- op encoding constants DIV/DIVU/REM/REMU.
- FSM state typedef.
- DIV0_QUOT=0xFFFFFFFF, INT_MIN=0x80000000.
REQ-026 Sub-module div_step SHALL be a combinational single restoring iteration.
- Inputs: partial remainder, dividend bit, divisor.
- Outputs: next partial remainder, quotient bit.
- Instantiated once in div_ctrl.

Verification
REQ-027 DIV -7 (0xFFFFFFF9) / 2 -> result 0xFFFFFFFD; out_valid exactly 34 cycles after acceptance.
REQ-028 REM -7 / 2 -> 0xFFFFFFFF; REMU 0xFFFFFFF9 / 2 -> 0x00000001; DIVU 0xFFFFFFF9 / 2 -> 0x7FFFFFFC.
REQ-029 Divisor zero: DIVU 100 / 0 -> 0xFFFFFFFF and REMU 100 / 0 -> 100, each with out_valid 1 cycle after acceptance.
REQ-030 Overflow: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 and REM -> 0, each in 1 cycle.
REQ-031 Backpressure: out_ready low for 5 cycles in DONE -> result stable, in_ready 0, busy 1; transfer on the 6th edge, in_ready 1 next cycle.
REQ-032 Reset asserted at CALC iteration 10 -> out_valid 0, busy 0, in_ready 1 immediately.
- With DIV_CTRL_FLUSH_EN: flush at iteration 10 -> IDLE at that edge, no out_valid pulse.
- A following DIV 20 / 3 -> 6.
